// File: rtl/sirv_gnrl_skidbuf_pkg.sv
// Purpose: shared state encodings and handshake helper for the skid buffer.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package sirv_gnrl_skidbuf_pkg;

  // Occupancy-coded states: the state value doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // A transfer happens on a cycle where both sides of the handshake agree.
  function automatic logic hs_fire(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Purpose: load-enabled register with asynchronous active-low clear to zero.
// Latency: 1 cycle from lden to qout.
// Backpressure: none; holds its value while lden is low.
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  // Capture dnxt only when enabled; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/sirv_gnrl_skidbuf.sv
// Purpose: two-entry registered valid/ready skid buffer (main + skid entry).
// Latency: 1 cycle from input handshake to o_vld when empty; 1 beat/cycle sustained.
// Backpressure: i_rdy drops (registered) only when both entries are occupied.
module sirv_gnrl_skidbuf
  import sirv_gnrl_skidbuf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    o_cnt
);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt;
  logic          state_ld;
  logic          main_ld;
  logic          skid_ld;
  logic          main_from_skid;
  logic [DW-1:0] main_nxt;
  logic [DW-1:0] skid_r;
  logic          in_fire;
  logic          out_fire;
  logic          i_rdy_r;
  logic          o_vld_r;

  assign in_fire  = hs_fire(i_vld, i_rdy_r);
  assign out_fire = hs_fire(o_vld_r, o_rdy);

  // Next-state and register-enable decode; illegal encodings fall back to EMPTY.
  always_comb begin
    state_nxt      = state_r;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt = ST_BUSY;
          main_ld   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_nxt = ST_FULL;
          skid_ld   = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // i_rdy is low here, so only the drain side can move.
        if (out_fire) begin
          state_nxt      = ST_BUSY;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign state_ld = (state_nxt != state_r);
  assign main_nxt = main_from_skid ? skid_r : i_dat;

  sirv_gnrl_dfflr #(.DW(2)) u_state_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (state_ld),
    .dnxt  (state_nxt),
    .qout  (state_r)
  );

  sirv_gnrl_dfflr #(.DW(DW)) u_main_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (main_ld),
    .dnxt  (main_nxt),
    .qout  (o_dat)
  );

  sirv_gnrl_dfflr #(.DW(DW)) u_skid_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (skid_ld),
    .dnxt  (i_dat),
    .qout  (skid_r)
  );

  // Handshake outputs are flopped from the next state so neither side sees a comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdy_r <= 1'b1;
      o_vld_r <= 1'b0;
    end else begin
      i_rdy_r <= (state_nxt != ST_FULL);
      o_vld_r <= (state_nxt == ST_BUSY) || (state_nxt == ST_FULL);
    end
  end

  assign i_rdy = i_rdy_r;
  assign o_vld = o_vld_r;
  assign o_cnt = state_r;

endmodule
